// File: rtl/and_32bitw.sv
// -----------------------------------------------------------------------------
// and_32bitw
//   Registered WIDTH-bit bitwise AND unit for the ALU datapath (o = a & b).
//   It has one output register stage. Both sides use a valid/ready handshake.
//   The unit also produces registered zero and all-ones flags for the
//   downstream branch and flag logic.
//
// Optional feature macro: AND_32BITW_PARITY_EN
//   When this macro is defined, the unit adds a registered even-parity output
//   (the XOR reduction of the captured result).
//
// Ports
//   clk       in   1      rising-edge clock
//   rst_n     in   1      synchronous active-low reset
//   a, b      in   WIDTH  operands
//   in_valid  in   1      operands valid this cycle
//   in_ready  out  1      unit can accept operands this cycle (combinational)
//   o         out  WIDTH  registered result a & b
//   out_valid out  1      o and the flags hold a valid result
//   out_ready in   1      consumer accepts the result this cycle
//   zero      out  1      registered flag: captured result is all zeros
//   ones      out  1      registered flag: captured result is all ones
//   parity    out  1      (AND_32BITW_PARITY_EN only) registered XOR of result
// -----------------------------------------------------------------------------
module and_32bitw #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] o,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             zero,
  output logic             ones
`ifdef AND_32BITW_PARITY_EN
  ,
  output logic             parity
`endif
);

  // Even parity of a result vector.
  function automatic logic calc_parity(input logic [WIDTH-1:0] v);
    calc_parity = ^v;
  endfunction

  // Flag helpers. They are kept as functions so that the flag encoding
  // lives in one place.
  function automatic logic is_all_zero(input logic [WIDTH-1:0] v);
    is_all_zero = ~(|v);
  endfunction

  function automatic logic is_all_ones(input logic [WIDTH-1:0] v);
    is_all_ones = &v;
  endfunction

  logic [WIDTH-1:0] o_q, o_d;
  logic             out_valid_q, out_valid_d;
  logic             zero_q, zero_d;
  logic             ones_q, ones_d;
  logic             parity_q, parity_d;
  logic             in_ready_s;
  logic             accept_s;
  logic [WIDTH-1:0] result_s;

  // Handshake decode. The stage is free when it is empty or when it is being
  // drained this cycle.
  always_comb begin
    in_ready_s = (~out_valid_q) | out_ready;
    accept_s   = in_valid & in_ready_s;
    result_s   = a & b;
  end

  // Next-state selection: accept (load), drain (clear valid only), or hold.
  always_comb begin
    o_d         = o_q;
    out_valid_d = out_valid_q;
    zero_d      = zero_q;
    ones_d      = ones_q;
    parity_d    = parity_q;
    if (accept_s) begin
      // Covers both the empty case and the simultaneous drain+accept case.
      o_d         = result_s;
      out_valid_d = 1'b1;
      zero_d      = is_all_zero(result_s);
      ones_d      = is_all_ones(result_s);
      parity_d    = calc_parity(result_s);
    end else if (out_valid_q && out_ready) begin
      // Drain without a replacement: the data and flags keep their stale values.
      out_valid_d = 1'b0;
    end else begin
      // Stall or idle: everything holds.
      out_valid_d = out_valid_q;
    end
  end

  // Output register stage with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_q         <= {WIDTH{1'b0}};
      out_valid_q <= 1'b0;
      zero_q      <= 1'b0;
      ones_q      <= 1'b0;
      parity_q    <= 1'b0;
    end else begin
      o_q         <= o_d;
      out_valid_q <= out_valid_d;
      zero_q      <= zero_d;
      ones_q      <= ones_d;
      parity_q    <= parity_d;
    end
  end

  // Output drive. Everything except in_ready comes directly from flops.
  always_comb begin
    in_ready  = in_ready_s;
    o         = o_q;
    out_valid = out_valid_q;
    zero      = zero_q;
    ones      = ones_q;
  end

`ifdef AND_32BITW_PARITY_EN
  // Parity output is taken directly from its flop.
  always_comb begin
    parity = parity_q;
  end
`endif

endmodule

// File: tb/tb_and_32bitw.sv
module tb_and_32bitw;

  logic        clk;
  logic        rst_n;
  logic [31:0] a;
  logic [31:0] b;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] o;
  logic        out_valid;
  logic        out_ready;
  logic        zero;
  logic        ones;
`ifdef AND_32BITW_PARITY_EN
  logic        parity;
`endif

  and_32bitw #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .o         (o),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .zero      (zero),
    .ones      (ones)
`ifdef AND_32BITW_PARITY_EN
    ,
    .parity    (parity)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] o;
    logic        z;
    logic        on;
    logic        p;
  } exp_t;

  exp_t        sb_q[$];
  int          n_assert = 0;
  int          n_fail   = 0;

  // Bench-side view of the output register.
  logic [31:0] m_o;
  logic        m_valid, m_zero, m_ones, m_par;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_valid"}, {31'd0, out_valid}, {31'd0, m_valid});
    check({tag, "_o"},     o,                  m_o);
    check({tag, "_zero"},  {31'd0, zero},      {31'd0, m_zero});
    check({tag, "_ones"},  {31'd0, ones},      {31'd0, m_ones});
`ifdef AND_32BITW_PARITY_EN
    check({tag, "_par"},   {31'd0, parity},    {31'd0, m_par});
`endif
  endtask

  // One cycle: drive at the negedge, check in_ready, clock it, then check the outputs.
  task automatic step(input string tag, input logic iv, input logic [31:0] ia,
                      input logic [31:0] ib, input logic ordy);
    logic acc;
    logic exp_rdy;
    exp_t e;
    a = ia; b = ib; in_valid = iv; out_ready = ordy;
    #1;
    exp_rdy = !m_valid || ordy;
    check({tag, "_in_ready"}, {31'd0, in_ready}, {31'd0, exp_rdy});
    acc = iv && exp_rdy;
    if (acc) begin
      e.o  = ia & ib;
      e.z  = (e.o == 32'h0000_0000);
      e.on = (e.o == 32'hFFFF_FFFF);
      e.p  = ^e.o;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    if (acc) begin
      if (sb_q.size() == 0) begin
        check({tag, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
        e = sb_q.pop_front();
        m_o = e.o; m_zero = e.z; m_ones = e.on; m_par = e.p; m_valid = 1'b1;
      end
    end else if (m_valid && ordy) begin
      m_valid = 1'b0;
    end
    check_outputs(tag);
    @(negedge clk);
  endtask

  task automatic do_reset(input string tag, input int cycles);
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
    repeat (cycles) @(posedge clk);
    #1;
    sb_q.delete();
    m_o = 32'h0; m_valid = 1'b0; m_zero = 1'b0; m_ones = 1'b0; m_par = 1'b0;
    check_outputs(tag);
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
    #1;
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] ra, rb;
    rst_n = 1'b0; a = 32'h0; b = 32'h0; in_valid = 1'b0; out_ready = 1'b0;
    m_o = 32'h0; m_valid = 1'b0; m_zero = 1'b0; m_ones = 1'b0; m_par = 1'b0;
    @(negedge clk);

    // Reset with in_valid high.
    do_reset("reset", 2);
    @(negedge clk);

    // Basic AND.
    step("basic", 1'b1, 32'hFFFF_2345, 32'hABCD_1235, 1'b1);
    check("basic_const", o, 32'hABCD_0205);
`ifdef AND_32BITW_PARITY_EN
    check("basic_par_const", {31'd0, parity}, 32'd1);
`endif

    // Flag tests.
    step("ones", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    check("ones_const", {31'd0, ones}, 32'd1);
    step("zero", 1'b1, 32'hAAAA_AAAA, 32'h5555_5555, 1'b1);
    check("zero_const", {31'd0, zero}, 32'd1);

    // Backpressure: stall for 3 cycles while the operands change.
    step("cap", 1'b1, 32'h1234_5678, 32'hF0F0_F0F0, 1'b1);
    step("stall0", 1'b1, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 1'b0);
    step("stall1", 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0);
    step("stall2", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check("stall_const", o, 32'h1030_5070);
    step("release", 1'b1, 32'h0F0F_0F0F, 32'h00FF_00FF, 1'b1);
    check("release_const", o, 32'h000F_000F);

    // Drain without new input, then idle.
    step("drain", 1'b0, 32'h1111_1111, 32'h2222_2222, 1'b1);
    step("idle", 1'b0, 32'h3333_3333, 32'h3333_3333, 1'b0);

    // Streaming: 8 random pairs at full throughput.
    for (int i = 0; i < 8; i++) begin
      ra = $urandom();
      rb = $urandom();
      step("stream", 1'b1, ra, rb, 1'b1);
    end

    // Reset in the middle of a stall.
    step("pre_stall", 1'b1, 32'hCAFE_F00D, 32'hFFFF_0000, 1'b0);
    step("held", 1'b1, 32'h0000_FFFF, 32'hFFFF_FFFF, 1'b0);
    do_reset("mid_reset", 1);
    @(negedge clk);
    step("post_reset", 1'b1, 32'h8000_0001, 32'hFFFF_FFFF, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
